// File: rtl/ysyx_23060221_ifu_pkg.sv
// ysyx_23060221_ifu_pkg: shared fetch FSM state and AXI encodings for the prefetcher.
package ysyx_23060221_ifu_pkg;
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DRAIN} ifu_state_e;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/ysyx_23060221_ifu_fifo.sv
// ysyx_23060221_ifu_fifo: synchronous FIFO with a flush that overrides push and pop.
module ysyx_23060221_ifu_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        do_push = push && !flush && cnt_q != FULL;
        do_pop = pop && cnt_q != '0;
        wr_d = flush ? '0 : wr_q + AW'(do_push);
        rd_d = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
    assign rdata = mem_q[rd_q];
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/ysyx_23060221_ifu_prefetch.sv
// ysyx_23060221_ifu_prefetch: AXI burst instruction prefetcher feeding a small instruction buffer.
module ysyx_23060221_ifu_prefetch
    import ysyx_23060221_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int DEPTH = 8,
    parameter int BURST_LEN = 4,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);
    localparam logic [31:0] BMASK = 32'(BURST_LEN*4 - 1);
    localparam int CW = $clog2(DEPTH) + 1;
    ifu_state_e state_q, state_d;
    logic [31:0] fpc_q, fpc_d, addr_q, addr_d, beat_pc;
    logic [4:0] beat_q, beat_d;
    logic pend_q, pend_d;
    logic push, pop, empty, room, unused_ok;
    logic [CW-1:0] count;
    assign beat_pc = addr_q + {25'd0, beat_q, 2'b00};
    assign room = 32'(count) + 32'(BURST_LEN) <= 32'(DEPTH);
    assign unused_ok = ^{rid, redirect_pc[1:0]};
    always_comb begin
        state_d = state_q;
        fpc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : fpc_q;
        addr_d = addr_q;
        beat_d = beat_q;
        pend_d = pend_q;
        push = 1'b0;
        case (state_q)
            S_IDLE: if (redirect_valid || room) begin
                state_d = S_AR;
                addr_d = fpc_d & ~BMASK;
            end
            // A redirect seen while the request is pending turns the burst into a drain.
            S_AR: begin
                pend_d = pend_q || redirect_valid;
                if (arready) begin
                    state_d = (pend_q || redirect_valid) ? S_DRAIN : S_R;
                    pend_d = 1'b0;
                    beat_d = '0;
                end
            end
            S_R: begin
                state_d = (rvalid && rlast) ? S_IDLE : redirect_valid ? S_DRAIN : S_R;
                if (rvalid) begin
                    push = !redirect_valid && beat_pc >= fpc_q;
                    beat_d = beat_q + 5'd1;
                    if (rlast && !redirect_valid) fpc_d = addr_q + 32'(BURST_LEN*4);
                end
            end
            S_DRAIN: state_d = (rvalid && rlast) ? S_IDLE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fpc_q <= RESET_PC;
            addr_q <= '0;
            beat_q <= '0;
            pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q <= fpc_d;
            addr_q <= addr_d;
            beat_q <= beat_d;
            pend_q <= pend_d;
        end
    end
    assign arvalid = state_q == S_AR;
    assign araddr = addr_q;
    assign arid = AXI_ID;
    assign arlen = 8'(BURST_LEN - 1);
    assign arsize = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign rready = state_q == S_R || state_q == S_DRAIN;
    assign out_valid = !empty;
    assign pop = out_valid && out_ready;
    ysyx_23060221_ifu_fifo #(.DEPTH(DEPTH), .WIDTH(65)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_valid),
        .push(push),
        .pop(pop),
        .wdata({rresp != AXI_RESP_OKAY, beat_pc, rdata}),
        .rdata({out_err, out_pc, out_inst}),
        .empty(empty),
        .count(count)
    );
endmodule

// File: doc/ysyx_23060221_ifu_prefetch.md
YSYX_23060221_IFU_PREFETCH -- requirements
Module: ysyx_23060221_ifu_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h80000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the instruction buffer entry count (power of 2, >= BURST_LEN).
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning beats per AXI read burst (power of 2, 1..16).
REQ-004 SHALL have parameter AXI_ID, default 4'd0, meaning the constant arid value.
REQ-005 SHALL have a single clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 redirect_valid  in  1  flush and restart fetch; redirect_pc  in  32  new fetch PC.
REQ-009 out_valid  out  1; out_ready  in  1; out_inst  out  32; out_pc  out  32; out_err  out  1 (bus error on this word).
REQ-010 arvalid out 1; arready in 1; araddr out 32; arid out 4; arlen out 8; arsize out 3; arburst out 2.
REQ-011 rvalid in 1; rready out 1; rdata in 32; rresp in 2; rlast in 1; rid in 4.

Function
REQ-012 SHALL keep fetch PC fpc; burst base = fpc with low log2(BURST_LEN*4) bits cleared; redirect_pc[1:0] ignored (treated as 0).
REQ-013 SHALL run FSM IDLE -> AR -> R -> IDLE, plus DRAIN; IDLE->AR only when buffer count + BURST_LEN <= DEPTH.
REQ-014 SHALL drive, in AR: arvalid=1, araddr=base, arlen=BURST_LEN-1, arsize=3'b010, arburst=INCR (2'b01), arid=AXI_ID; all stable until arready.
REQ-015 SHALL move AR->R on arvalid&arready; rready=1 throughout R and DRAIN, 0 elsewhere.
REQ-016 SHALL push beat k (pc=base+4k) on rvalid&rready in R only when base+4k >= fpc; earlier beats are dropped.
REQ-017 SHALL set the entry's err bit when rresp != 2'b00; the word is still pushed.
REQ-018 SHALL, on the rlast beat in R, set fpc = base + BURST_LEN*4 and go to IDLE (32-bit wrap-around permitted).
REQ-019 SHALL drive out_valid = buffer non-empty, with out_inst/out_pc/out_err taken from the head entry; pop on out_valid&out_ready.
REQ-020 SHALL, on redirect_valid: empty the buffer next cycle, set fpc=redirect_pc, and drop any beat arriving in that cycle.
REQ-021 SHALL, on redirect in IDLE, go to AR next cycle; on redirect in R go to DRAIN; on redirect in AR keep arvalid until handshake, then go to DRAIN.
REQ-022 SHALL in DRAIN discard beats until rlast, then go to IDLE without pushing.
REQ-023 SHALL, on simultaneous redirect and out handshake, complete the pop and flush the remaining entries.
REQ-024 SHALL ignore rid (single outstanding burst); a second redirect during DRAIN only updates fpc.
REQ-025 SHALL have out_valid combinational from registers only (no path from rvalid to out_valid).

Reset
REQ-026 SHALL on rst set state=IDLE, fpc=RESET_PC, buffer empty, arvalid=0, rready=0, out_valid=0, araddr=0.
REQ-027 SHALL abandon an in-flight burst on rst without DRAIN (slave is reset together).
REQ-028 SHALL assert arvalid with araddr=RESET_PC base at the 2nd rising edge after rst deasserts (IDLE->AR).

Structure
REQ-029 SHALL place the FSM state enum and the constants AXI_BURST_INCR, AXI_SIZE_4B and AXI_RESP_OKAY in shared package ysyx_23060221_ifu_pkg.
REQ-030 SHALL instantiate the buffer as sub-module ysyx_23060221_ifu_fifo (sync FIFO, 65-bit entries {err,pc,inst}, depth DEPTH, with flush).

Verification
REQ-031 Reset, BURST_LEN=4: arvalid with araddr=0x80000000, arlen=3; beats 0x11,0x22,0x33,0x44 -> out_pc 0x80000000..0x8000000C in order; next araddr=0x80000010.
REQ-032 out_ready=0, DEPTH=8: exactly two bursts are issued, then arvalid stays 0 until at least 4 entries pop.
REQ-033 Redirect to 0x80000108 in IDLE: araddr=0x80000100; beats at 0x100 and 0x104 dropped; first out_pc=0x80000108.
REQ-034 Redirect to 0x80000200 mid-burst after beat 1: remaining beats drained, no push; next araddr=0x80000200; no stale out_pc seen.
REQ-035 rresp=2'b10 on beat 2 -> entry out_pc=base+8 with out_err=1, other entries out_err=0.
REQ-036 arready held low 5 cycles with redirect during cycle 2: araddr unchanged until handshake, then DRAIN, then new burst.
